// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
// One request is held until ack; rdata is valid in the ack cycle.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores on the data bus, stalls upstream while a
// transfer is outstanding, formats load/store data and registers writeback.
//
// state | meaning
// IDLE  | no transfer outstanding; pass-through, trap or issue
// BUSY  | request on the bus, waiting for ack or watchdog expiry
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ex_mb__alu_y,
  input  logic [31:0] ex_mb__rs2_rdata,
  input  logic [31:0] ex_mb__pc_4,
  input  logic [4:0]  ex_mb__rd_addr,
  input  logic        ex_mb__rd_wen,
  input  logic        ex_mb__mem_read,
  input  logic        ex_mb__mem_write,
  input  logic [2:0]  ex_mb__funct3,
  input  logic [1:0]  ex_mb__rd_src,
  output logic        stall,
  mem_access_if.master dbus,
  output logic [4:0]  mb_wb__rd_addr,
  output logic        mb_wb__rd_wen,
  output logic [31:0] mb_wb__rd_wdata,
  output logic        mb_wb__trap,
  output logic [1:0]  mb_wb__trap_cause
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          req_q, req_d, we_q, we_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [4:0]    wb_addr_d;
  logic          wb_wen_d, trap_d;
  logic [31:0]   wb_wdata_d;
  logic [1:0]    cause_d;

  logic          access, is_load, size_bad, misaligned, bad, wen_ok, tmo_hit;
  logic [3:0]    be_c;
  logic [31:0]   st_wdata, ld_val, wb_val, pass_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;
  assign dbus.be    = be_q;

  assign access     = ex_mb__mem_read | ex_mb__mem_write;
  assign is_load    = ex_mb__mem_read;
  assign size_bad   = (ex_mb__funct3 == 3'b011) || (ex_mb__funct3 == 3'b110) ||
                      (ex_mb__funct3 == 3'b111);
  assign misaligned = ((ex_mb__funct3[1:0] == 2'b01) && ex_mb__alu_y[0]) ||
                      ((ex_mb__funct3[1:0] == 2'b10) && (ex_mb__alu_y[1:0] != 2'b00));
  assign bad        = size_bad | misaligned;
  assign wen_ok     = ex_mb__rd_wen & (ex_mb__rd_addr != 5'd0);
  assign pass_val   = (ex_mb__rd_src == 2'd2) ? ex_mb__pc_4 : ex_mb__alu_y;
  // ack has priority over the watchdog in the final allowed cycle
  assign tmo_hit    = TMO_EN && (tmo_q == TMO_LAST) && !dbus.ack;

  always_comb begin
    be_c     = 4'b1111;
    st_wdata = ex_mb__rs2_rdata;
    case (ex_mb__funct3[1:0])
      2'b00: begin
        be_c     = 4'b0001 << ex_mb__alu_y[1:0];
        st_wdata = {4{ex_mb__rs2_rdata[7:0]}};
      end
      2'b01: begin
        be_c     = ex_mb__alu_y[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_mb__rs2_rdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ex_mb__alu_y[1:0])
      2'b00:   ld_byte = dbus.rdata[7:0];
      2'b01:   ld_byte = dbus.rdata[15:8];
      2'b10:   ld_byte = dbus.rdata[23:16];
      default: ld_byte = dbus.rdata[31:24];
    endcase
    ld_half = ex_mb__alu_y[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    case (ex_mb__funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = dbus.rdata;
    endcase
    case (ex_mb__rd_src)
      2'd1:    wb_val = ld_val;
      2'd2:    wb_val = ex_mb__pc_4;
      default: wb_val = ex_mb__alu_y;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    stall      = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_addr_d  = ex_mb__rd_addr;
    wb_wen_d   = 1'b0;
    wb_wdata_d = pass_val;
    trap_d     = 1'b0;
    cause_d    = 2'd0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (!access) begin
          wb_wen_d = wen_ok;
        end else if (bad) begin
          trap_d  = 1'b1;
          cause_d = size_bad ? 2'd2 : (is_load ? 2'd0 : 2'd1);
        end else begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = ~is_load;
          addr_d  = {ex_mb__alu_y[31:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = be_c;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dbus.ack) begin
          req_d      = 1'b0;
          state_d    = IDLE;
          tmo_d      = '0;
          wb_wen_d   = is_load & wen_ok;
          wb_wdata_d = wb_val;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          state_d = IDLE;
          tmo_d   = '0;
          trap_d  = 1'b1;
          cause_d = 2'd3;
        end else begin
          stall = 1'b1;
          if (TMO_EN) tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      tmo_q             <= '0;
      req_q             <= 1'b0;
      we_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      be_q              <= '0;
      mb_wb__rd_addr    <= '0;
      mb_wb__rd_wen     <= 1'b0;
      mb_wb__rd_wdata   <= '0;
      mb_wb__trap       <= 1'b0;
      mb_wb__trap_cause <= '0;
    end else begin
      state_q           <= state_d;
      tmo_q             <= tmo_d;
      req_q             <= req_d;
      we_q              <= we_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      be_q              <= be_d;
      mb_wb__rd_addr    <= wb_addr_d;
      mb_wb__rd_wen     <= wb_wen_d;
      mb_wb__rd_wdata   <= wb_wdata_d;
      mb_wb__trap       <= trap_d;
      mb_wb__trap_cause <= cause_d;
    end
  end

endmodule
